// File: rtl/uart_pkg.sv
// UART register map, ASCII constants and nibble-to-hex helper shared by the
// flash dump path and the command-echo logic.
package uart_pkg;

    localparam logic [3:0] TX_RDY = 4'h0;
    localparam logic [3:0] TX_DAT = 4'h1;
    localparam logic [3:0] RX_RDY = 4'h2;
    localparam logic [3:0] RX_DAT = 4'h3;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    typedef enum logic [2:0] {
        P_IDLE,
        P_POLL,
        P_GAP,
        P_CHK,
        P_SEND,
        P_GAP2
    } putc_state_e;

    // Uppercase ASCII: 0x30..0x39 for 0..9, 0x41..0x46 for A..F.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_putc.sv
// One-character UART transmit: poll TX_RDY until nonzero, then write TX_DAT.
// A new character may be accepted in the idle state or in the final gap cycle.
module uart_putc
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic [7:0] i_char,
    output logic       o_done,
    output logic       o_uart_en,
    output logic       o_uart_wr,
    output logic [3:0] o_uart_addr,
    output logic [7:0] o_uart_wdata,
    input  logic [7:0] i_uart_rdata
);

    putc_state_e state_q, state_d;
    logic [7:0]  char_q, char_d;
    logic        en_q, en_d;
    logic        wr_q, wr_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= P_IDLE;
            char_q  <= 8'h00;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 4'h0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        case (state_q)
            P_IDLE: begin
                if (i_go) begin
                    state_d = P_POLL;
                    char_d  = i_char;
                end
            end
            P_POLL: state_d = P_GAP;
            P_GAP:  state_d = P_CHK;
            P_CHK:  state_d = (i_uart_rdata != 8'h00) ? P_SEND : P_POLL;
            P_SEND: state_d = P_GAP2;
            P_GAP2: begin
                if (i_go) begin
                    state_d = P_POLL;
                    char_d  = i_char;
                end else begin
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase

        // Bus outputs are registered from the next state so each access is one clean cycle.
        en_d    = (state_d == P_POLL) || (state_d == P_SEND);
        wr_d    = (state_d == P_SEND);
        addr_d  = wr_d ? TX_DAT : TX_RDY;
        wdata_d = wr_d ? char_d : 8'h00;
    end

    assign o_done       = (state_q == P_GAP2);
    assign o_uart_en    = en_q;
    assign o_uart_wr    = wr_q;
    assign o_uart_addr  = addr_q;
    assign o_uart_wdata = wdata_q;

endmodule

// File: rtl/hex_dump.sv
// Byte stream to address-prefixed hex lines ("0100: DE AD BE EF" CR LF),
// written character by character to the UART through uart_putc.
module hex_dump
    import uart_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int ADDR_W         = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_uart_en,
    output logic              o_uart_wr,
    output logic [3:0]        o_uart_addr,
    output logic [7:0]        o_uart_wdata,
    input  logic [7:0]        i_uart_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} state_e;

    localparam int ND    = ADDR_W / 4;
    localparam int SW    = $clog2(ND + 7);
    localparam int COL_W = 5;

    // Character steps: address digits 0..ND-1, then fixed punctuation/data slots.
    localparam logic [SW-1:0] ST_COLON = SW'(ND);
    localparam logic [SW-1:0] ST_SPACE = SW'(ND + 1);
    localparam logic [SW-1:0] ST_HI    = SW'(ND + 2);
    localparam logic [SW-1:0] ST_LO    = SW'(ND + 3);
    localparam logic [SW-1:0] ST_CR    = SW'(ND + 4);
    localparam logic [SW-1:0] ST_LF    = SW'(ND + 5);
    localparam logic [SW-1:0] ST_END   = SW'(ND + 6);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BYTES_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [7:0]        byte_q, byte_d;
    logic              last_q, last_d;
    logic [SW-1:0]     step_q, step_d;
    logic              infl_q, infl_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic       go;
    logic [7:0] ch;
    logic       nl;
    logic       avail;
    logic       putc_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            step_q  <= '0;
            infl_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            step_q  <= step_d;
            infl_q  <= infl_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        byte_d  = byte_q;
        last_d  = last_q;
        step_d  = step_q;
        busy_d  = busy_q;
        go      = 1'b0;
        nl      = (col_q == COL_LAST) || last_q;
        // putc can take a character when nothing is in flight or it is finishing one.
        avail   = !infl_q || putc_done;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_valid && ready_q) begin
                    byte_d  = i_data;
                    last_d  = i_last;
                    step_d  = (col_q == '0) ? '0 : ST_SPACE;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (avail) begin
                    if (step_q == ST_END) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        col_d   = nl ? '0 : col_q + COL_W'(1);
                        state_d = last_q ? S_DONE : S_WAIT;
                    end else begin
                        go = 1'b1;
                        if (step_q == ST_LO)      step_d = nl ? ST_CR : ST_END;
                        else if (step_q == ST_LF) step_d = ST_END;
                        else                      step_d = step_q + SW'(1);
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_WAIT);
        infl_d  = go ? 1'b1 : (putc_done ? 1'b0 : infl_q);
    end

    always_comb begin
        ch = 8'h00;
        for (int i = 0; i < ND; i++) begin
            if (step_q == SW'(i)) ch = hex_char(addr_q[4*(ND-1-i) +: 4]);
        end
        if (step_q == ST_COLON) ch = ASCII_COLON;
        if (step_q == ST_SPACE) ch = ASCII_SP;
        if (step_q == ST_HI)    ch = hex_char(byte_q[7:4]);
        if (step_q == ST_LO)    ch = hex_char(byte_q[3:0]);
        if (step_q == ST_CR)    ch = ASCII_CR;
        if (step_q == ST_LF)    ch = ASCII_LF;
    end

    uart_putc u_putc (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_go         (go),
        .i_char       (ch),
        .o_done       (putc_done),
        .o_uart_en    (o_uart_en),
        .o_uart_wr    (o_uart_wr),
        .o_uart_addr  (o_uart_addr),
        .o_uart_wdata (o_uart_wdata),
        .i_uart_rdata (i_uart_rdata)
    );

    assign o_ready = ready_q;
    assign o_busy  = busy_q;

endmodule

// File: doc/hex_dump.md
# hex_dump

Byte-stream to UART hex-dump formatter; the consumer stage between a flash read sequencer and the `uart` register interface. It accepts bytes over a valid/ready stream and prints them as address-prefixed hex lines, e.g. `0100: DE AD BE EF`. It drives the UART device registers itself, polling TX_RDY before every TX_DAT write. It is the output half of the flash dump path in the physical test bench.

## Interface
- `BYTES_PER_LINE`, 16: data bytes per output line; power of two, 1..16.
- `ADDR_W`, 16: address counter width; multiple of 4. The header prints `ADDR_W/4` hex digits.

Clock and reset (already decided): one clock; reset is synchronous and active-high. Ports are named `i_clk` and `i_rst`.

- `i_clk`  in  1  system clock (12 MHz in the bench).
- `i_rst`  in  1  synchronous active-high reset.
- `i_start`  in  1  one-cycle pulse; loads `i_base`, enters the stream-wait state.
- `i_base`  in  ADDR_W  address of the first byte.
- `i_valid`  in  1  stream byte valid.
- `i_data`  in  8  stream byte.
- `i_last`  in  1  marks the final byte; qualified by `i_valid`.
- `o_ready`  out  1  stream ready.
- `o_busy`  out  1  high from an accepted `i_start` until the final character is written.
- `o_uart_en`  out  1  UART register access strobe.
- `o_uart_wr`  out  1  UART write qualifier.
- `o_uart_addr`  out  4  UART register select.
- `o_uart_wdata`  out  8  character to transmit.
- `i_uart_rdata`  in  8  UART register read data.

## Operation
- States: IDLE, WAIT_BYTE, EMIT, DONE.
- EMIT steps through its character sequence through the `uart_putc` handshake.
- IDLE:
  - `i_start` loads the address counter from `i_base`, clears the column counter, sets `o_busy`, and moves to WAIT_BYTE.
  - `i_start` is ignored outside IDLE.
- WAIT_BYTE:
  - `o_ready` is high only in this state.
  - On `i_valid && o_ready`, the byte and `i_last` are latched and the state moves to EMIT.
- EMIT sequence for each byte:
  - If column == 0: address digits MSB first, then `:`.
  - Then space, high nibble, low nibble.
- After the byte:
  - Address and column increment.
  - If column reaches `BYTES_PER_LINE` or the latched last flag is set, emit CR (0x0D) and LF (0x0A), then clear column.
  - If last: go to DONE. Otherwise: go to WAIT_BYTE.
- DONE: drops `o_busy`, returns to IDLE.
- Hex digits are uppercase ASCII: 0x30–0x39, 0x41–0x46.
- Address counter wraps modulo 2^ADDR_W. The wrap does not force a new line; the next header shows the wrapped value.
- An empty stream (start, never valid) prints nothing; the block stays in WAIT_BYTE.
- `uart_putc` handshake, per character:
  1. POLL: en=1, wr=0, addr=TX_RDY.
  2. GAP: en=0.
  3. CHK: `i_uart_rdata` != 0 goes to SEND; == 0 goes back to POLL.
  4. SEND: en=1, wr=1, addr=TX_DAT, wdata=char.
  5. GAP2: en=0, wr=0. Character done.
- Reset, any state: every output 0 on the next edge, FSM to IDLE, counters cleared. A pending character is discarded.

## Timing
- Reset values: `o_ready`, `o_busy`, `o_uart_en`, `o_uart_wr` = 0; `o_uart_addr` = 0; `o_uart_wdata` = 0.
- `o_uart_en` is high for exactly one cycle per access. `o_uart_wr` is high only together with `o_uart_en`.
- Minimum cost is 5 cycles per character when TX_RDY reads nonzero on the first poll. Each failed poll adds 3 cycles.
- Full 16-byte line with ADDR_W=16: 55 characters (4 address digits, `:`, 48, CR, LF), so at least 275 cycles.
- Byte accept to first POLL: 1 cycle.
- Final GAP2 to `o_busy` low: 2 cycles (DONE, then IDLE).
- All outputs are registered.

## Structure
- Shared package `uart_pkg`:
  - UART register addresses TX_RDY=4'h0, TX_DAT=4'h1, RX_RDY=4'h2, RX_DAT=4'h3.
  - ASCII constants for CR, LF, space, colon.
  - Nibble-to-hex function.
- Sub-module `uart_putc`:
  - Implements the POLL/GAP/CHK/SEND/GAP2 handshake.
  - Ports: `i_clk`, `i_rst`, `i_go`, `i_char`, `o_done`, plus the UART bus.
  - Reused by the later command-echo logic.
- `hex_dump` owns the formatting FSM, the address and column counters, and the character selection mux.

## Test plan
- Single byte: start with base 16'h1234, send 8'hA5 with last. UART model always ready. Expect TX_DAT sequence "1234: A5" CR LF, then `o_busy` low.
- Full line: base 0, bytes 00..0F, last on 0F. Expect one line "0000: 00 01 … 0F" CR LF, 55 writes total.
- Line break: base 0, 17 bytes, last on the 17th. Expect the first line terminated with CR LF, then a second line "0010: 10" CR LF.
- Backpressure: model returns 0 on TX_RDY for 3 polls before each character. Expect no TX_DAT write before a nonzero poll, and the same byte sequence as the single-byte case.
- Wrap: base 16'hFFFF, 2 bytes 11, 22, BYTES_PER_LINE=2. Expect "FFFF: 11 22" CR LF. A third byte with BYTES_PER_LINE=1 prints header "0000:".
- Reset and stray start: assert `i_rst` during a SEND cycle. Expect all outputs 0 next cycle and no further writes. Pulse `i_start` while busy: expect no reload and unchanged output.
